shift_reg_buttons: RTL and testbench

//  Parametrised bidirectional shift register driven by raw active-low push buttons.

---
 rtl/shift_reg_buttons.sv | 187 ++++++++++++++++++
 tb/tb_shift_reg_buttons.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/shift_reg_buttons.sv
// Button-driven bidirectional shift register: sync, debounce, auto-repeat, rotate and parallel load.
// Latency: press stable before edge k -> q updates at edge k+DEBOUNCE+3; no backpressure, losing events dropped.

module srb_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic stable
);
  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchroniser inverts so that 1 means pressed from here on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= ~btn_n;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module srb_repeat #(
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250,
  parameter int REPEAT_EN     = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic stable,
  output logic fire
);
  localparam int MAXC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RPT, HELD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          fire_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      fire  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fire  <= fire_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (stable) begin
          fire_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = (REPEAT_EN != 0) ? DELAY : HELD;
        end
      end
      DELAY: begin
        if (!stable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DLY_LAST) begin
          fire_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RPT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RPT: begin
        if (!stable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == PER_LAST) begin
          fire_nxt = 1'b1;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!stable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

module shift_reg_buttons #(
  parameter int WIDTH         = 8,
  parameter int DEBOUNCE      = 16,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250,
  parameter int REPEAT_EN     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_left_n,
  input  logic             btn_right_n,
  input  logic             btn_load_n,
  input  logic             ser_lsb,
  input  logic             ser_msb,
  input  logic             rotate,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             step
);
  logic stable_left;
  logic stable_right;
  logic stable_load;
  logic fire_left;
  logic fire_right;
  logic fire_load;

  srb_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_left (
    .clk(clk), .reset(reset), .btn_n(btn_left_n), .stable(stable_left)
  );
  srb_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_right (
    .clk(clk), .reset(reset), .btn_n(btn_right_n), .stable(stable_right)
  );
  srb_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_load (
    .clk(clk), .reset(reset), .btn_n(btn_load_n), .stable(stable_load)
  );

  srb_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(REPEAT_EN)
  ) u_rp_left (
    .clk(clk), .reset(reset), .stable(stable_left), .fire(fire_left)
  );
  srb_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(REPEAT_EN)
  ) u_rp_right (
    .clk(clk), .reset(reset), .stable(stable_right), .fire(fire_right)
  );
  // Load never auto-repeats: one event per press.
  srb_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(0)
  ) u_rp_load (
    .clk(clk), .reset(reset), .stable(stable_load), .fire(fire_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      step <= 1'b0;
    end else begin
      step <= fire_load | fire_left | fire_right;
      if (fire_load) begin
        q <= load_data;
      end else if (fire_left) begin
        q <= {q[WIDTH-2:0], rotate ? q[WIDTH-1] : ser_lsb};
      end else if (fire_right) begin
        q <= {rotate ? q[0] : ser_msb, q[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: tb/tb_shift_reg_buttons.sv
// Scoreboard bench: stimulus pushes expected (cycle, q) pairs; monitor pops on every step pulse.
module tb_shift_reg_buttons;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       left1 = 1'b1, right1 = 1'b1, load1 = 1'b1;
  logic       left2 = 1'b1, right2 = 1'b1, load2 = 1'b1;
  logic       ser_lsb = 1'b0, ser_msb = 1'b0, rotate = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic [7:0] q1, q2;
  logic       step1, step2;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t exp1[$];
  exp_t exp2[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_reg_buttons #(.WIDTH(8), .DEBOUNCE(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .REPEAT_EN(1)) u_rpt (
    .clk(clk), .reset(reset), .btn_left_n(left1), .btn_right_n(right1), .btn_load_n(load1),
    .ser_lsb(ser_lsb), .ser_msb(ser_msb), .rotate(rotate), .load_data(load_data),
    .q(q1), .step(step1)
  );

  shift_reg_buttons #(.WIDTH(8), .DEBOUNCE(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .REPEAT_EN(0)) u_once (
    .clk(clk), .reset(reset), .btn_left_n(left2), .btn_right_n(right2), .btn_load_n(load2),
    .ser_lsb(ser_lsb), .ser_msb(ser_msb), .rotate(rotate), .load_data(load_data),
    .q(q2), .step(step2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push1(input int c, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp1.push_back(e);
  endtask

  task automatic push2(input int c, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp2.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every step pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (step1) begin
      if (exp1.size() == 0) begin
        check("u_rpt unexpected step q", {24'd0, q1}, 32'hFFFF_FFFF);
      end else begin
        e = exp1.pop_front();
        check("u_rpt q", {24'd0, q1}, {24'd0, e.val});
        check("u_rpt cycle", cyc, e.cyc);
      end
    end
    if (step2) begin
      if (exp2.size() == 0) begin
        check("u_once unexpected step q", {24'd0, q2}, 32'hFFFF_FFFF);
      end else begin
        e = exp2.pop_front();
        check("u_once q", {24'd0, q2}, {24'd0, e.val});
        check("u_once cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int p;
    wait_neg(3);
    check("reset q1", {24'd0, q1}, 32'd0);
    check("reset q2", {24'd0, q2}, 32'd0);
    check("reset step1", {31'd0, step1}, 32'd0);
    reset = 1'b0;
    wait_neg(5);

    // Load A5, then async reset in the middle of a cycle.
    load_data = 8'hA5;
    p = cyc; load1 = 1'b0; push1(p + 8, 8'hA5);
    wait_neg(10); load1 = 1'b1;
    wait_neg(10);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("async reset q1", {24'd0, q1}, 32'd0);
    check("async reset step1", {31'd0, step1}, 32'd0);
    wait_neg(2); reset = 1'b0;
    wait_neg(20);

    // Bounce: 3-cycle press is shorter than debounce window.
    left1 = 1'b0; wait_neg(3); left1 = 1'b1;
    wait_neg(20);
    check("bounce q1", {24'd0, q1}, 32'd0);

    // Hold left 40 cycles with serial 1: first event, delay, then repeats.
    ser_lsb = 1'b1; rotate = 1'b0;
    p = cyc; left1 = 1'b0;
    push1(p + 8,  8'h01);
    push1(p + 28, 8'h03);
    push1(p + 33, 8'h07);
    push1(p + 38, 8'h0F);
    push1(p + 43, 8'h1F);
    wait_neg(40); left1 = 1'b1;
    wait_neg(20);

    // Left and right together from q=01: left wins.
    ser_lsb = 1'b0; ser_msb = 1'b1; load_data = 8'h01;
    p = cyc; load1 = 1'b0; push1(p + 8, 8'h01);
    wait_neg(10); load1 = 1'b1; wait_neg(10);
    p = cyc; left1 = 1'b0; right1 = 1'b0; push1(p + 8, 8'h02);
    wait_neg(10); left1 = 1'b1; right1 = 1'b1; wait_neg(10);

    // Load and left qualify on the same edge: load wins.
    load_data = 8'h3C;
    p = cyc; load1 = 1'b0; left1 = 1'b0; push1(p + 8, 8'h3C);
    wait_neg(10); load1 = 1'b1; left1 = 1'b1; wait_neg(10);

    // Non-repeating instance: rotate right of 81 once while held 50 cycles.
    load_data = 8'h81;
    p = cyc; load2 = 1'b0; push2(p + 8, 8'h81);
    wait_neg(10); load2 = 1'b1; wait_neg(10);
    rotate = 1'b1;
    p = cyc; right2 = 1'b0; push2(p + 8, 8'hC0);
    wait_neg(50); right2 = 1'b1;
    wait_neg(20);

    check("u_rpt pending expectations", exp1.size(), 32'd0);
    check("u_once pending expectations", exp2.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
